// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the RF echo decoder.
// Decoder states, rejection codes and the default counter width.
package rf_seq_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_P1,
        S_G1,
        S_P2,
        S_G2,
        S_P3,
        S_REPORT
    } state_e;

    localparam logic [2:0] ERR_NONE          = 3'd0;
    localparam logic [2:0] ERR_PI_RATIO      = 3'd1;
    localparam logic [2:0] ERR_PI2_MISMATCH  = 3'd2;
    localparam logic [2:0] ERR_GAP_ASYM      = 3'd3;
    localparam logic [2:0] ERR_GAP_TIMEOUT   = 3'd4;
    localparam logic [2:0] ERR_PULSE_TIMEOUT = 3'd5;

endpackage

// File: rtl/rf_echo_decoder_if.sv
// Control/result bundle of the RF echo decoder.
// master: the side that drives arm/rf and consumes results; slave: the decoder.
interface rf_echo_decoder_if #(
    parameter int CNT_W = rf_seq_pkg::DEF_CNT_W
) ();
    logic             arm;
    logic             rf;
    logic             busy;
    logic             seq_valid;
    logic             seq_err;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] t_pi2_a;
    logic [CNT_W-1:0] t_gap1;
    logic [CNT_W-1:0] t_pi;
    logic [CNT_W-1:0] t_gap2;
    logic [CNT_W-1:0] t_pi2_b;
    logic [15:0]      seq_count;

    modport master (
        output arm, rf,
        input  busy, seq_valid, seq_err, err_code,
        input  t_pi2_a, t_gap1, t_pi, t_gap2, t_pi2_b, seq_count
    );

    modport slave (
        input  arm, rf,
        output busy, seq_valid, seq_err, err_code,
        output t_pi2_a, t_gap1, t_pi, t_gap2, t_pi2_b, seq_count
    );
endinterface

// File: rtl/rf_run_counter.sv
// Edge detector and saturating run-length counter for the rf gate.
// Optional macro RF_SYNC_EN inserts a 2-flop synchronizer ahead of the
// edge detector; lengths are unaffected, only latency grows by 2 cycles.
// run_len is the number of cycles the previous sampled level lasted when
// read in an edge cycle, and (current run - 1) otherwise.
module rf_run_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rf,
    output logic             rise,
    output logic             fall,
    output logic             level,
    output logic [CNT_W-1:0] run_len
);

    logic             rf_s;
    logic             rf_d, rf_q;
    logic [CNT_W-1:0] run_d, run_q;

`ifdef RF_SYNC_EN
    logic [1:0] sync_d, sync_q;

    // shift the raw gate through two flops before it is used
    always_comb sync_d = {sync_q[0], rf};

    // synchronizer register
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign rf_s = sync_q[1];
`else
    assign rf_s = rf;
`endif

    // edge detect and run counter next-state; reload to 1 on any edge
    always_comb begin
        rf_d = rf_s;
        rise = rf_s & ~rf_q;
        fall = ~rf_s & rf_q;
        if (rise || fall)      run_d = CNT_W'(1);
        else if (&run_q)       run_d = run_q;
        else                   run_d = run_q + CNT_W'(1);
    end

    // sample register and run counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q  <= 1'b0;
            run_q <= '0;
        end else begin
            rf_q  <= rf_d;
            run_q <= run_d;
        end
    end

    assign level   = rf_s;
    assign run_len = run_q;

endmodule

// File: rtl/rf_echo_decoder.sv
// RF echo decoder: decodes pi/2 - gap - pi - gap - pi/2 on the rf gate,
// measures each segment and checks echo consistency. One strobe per
// sequence (seq_valid or seq_err), registered so it appears in the
// REPORT cycle (or the cycle after a timeout is detected).
// Optional macro RF_SYNC_EN: synchronize rf before decoding (+2 latency).
module rf_echo_decoder
    import rf_seq_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TOL       = 2,
    parameter int MAX_GAP   = 1000,
    parameter int MAX_PULSE = 500
) (
    input logic              clk,
    input logic              rst,
    rf_echo_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(MAX_GAP);
    localparam logic [CNT_W-1:0] PULSE_LIM = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W:0]   TOL_W     = (CNT_W+1)'(TOL);

    logic             rise, fall, level;
    logic [CNT_W-1:0] run_len;

    rf_run_counter #(.CNT_W(CNT_W)) u_run (
        .clk     (clk),
        .rst     (rst),
        .rf      (bus.rf),
        .rise    (rise),
        .fall    (fall),
        .level   (level),
        .run_len (run_len)
    );

    state_e           state_d, state_q;
    logic             seq_valid_d, seq_valid_q;
    logic             seq_err_d, seq_err_q;
    logic [2:0]       err_code_d, err_code_q;
    logic [15:0]      seq_count_d, seq_count_q;
    // published lengths, only rewritten on a completed sequence
    logic [CNT_W-1:0] t_pi2a_d, t_pi2a_q;
    logic [CNT_W-1:0] t_gap1_d, t_gap1_q;
    logic [CNT_W-1:0] t_pi_d,   t_pi_q;
    logic [CNT_W-1:0] t_gap2_d, t_gap2_q;
    logic [CNT_W-1:0] t_pi2b_d, t_pi2b_q;
    // in-flight measurements of the current sequence
    logic [CNT_W-1:0] m_pi2a_d, m_pi2a_q;
    logic [CNT_W-1:0] m_gap1_d, m_gap1_q;
    logic [CNT_W-1:0] m_pi_d,   m_pi_q;
    logic [CNT_W-1:0] m_gap2_d, m_gap2_q;

    logic [CNT_W:0]   d_ratio, d_pi2, d_gap;
    logic [2:0]       chk_code;
    logic             gap_to, pulse_to;

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] x,
                                                input logic [CNT_W:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    // consistency checks, evaluated in the P3 fall cycle where run_len is t_pi2_b
    always_comb begin
        d_ratio = abs_diff({1'b0, m_pi_q}, {m_pi2a_q, 1'b0});
        d_pi2   = abs_diff({1'b0, run_len}, {1'b0, m_pi2a_q});
        d_gap   = abs_diff({1'b0, m_gap2_q}, {1'b0, m_gap1_q});
        if (d_ratio > TOL_W)    chk_code = ERR_PI_RATIO;
        else if (d_pi2 > TOL_W) chk_code = ERR_PI2_MISMATCH;
        else if (d_gap > TOL_W) chk_code = ERR_GAP_ASYM;
        else                    chk_code = ERR_NONE;
    end

    // current run has reached limit+1 cycles (run_len counts the earlier ones)
    assign gap_to   = ~level & (run_len >= GAP_LIM);
    assign pulse_to =  level & (run_len >= PULSE_LIM);

    // sequence FSM: next state, measurement latches and strobes
    always_comb begin
        state_d     = state_q;
        seq_valid_d = 1'b0;
        seq_err_d   = 1'b0;
        err_code_d  = err_code_q;
        seq_count_d = seq_count_q;
        t_pi2a_d    = t_pi2a_q;
        t_gap1_d    = t_gap1_q;
        t_pi_d      = t_pi_q;
        t_gap2_d    = t_gap2_q;
        t_pi2b_d    = t_pi2b_q;
        m_pi2a_d    = m_pi2a_q;
        m_gap1_d    = m_gap1_q;
        m_pi_d      = m_pi_q;
        m_gap2_d    = m_gap2_q;

        if (!bus.arm && state_q != S_IDLE) begin
            // silent abort; wins over any timeout in the same cycle
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (bus.arm) state_d = S_WAIT_LOW;
                S_WAIT_LOW: if (rise) state_d = S_P1;
                S_P1: begin
                    if (fall) begin
                        m_pi2a_d = run_len;
                        state_d  = S_G1;
                    end else if (pulse_to) begin
                        seq_err_d  = 1'b1;
                        err_code_d = ERR_PULSE_TIMEOUT;
                        state_d    = S_WAIT_LOW;
                    end
                end
                S_G1: begin
                    if (rise) begin
                        m_gap1_d = run_len;
                        state_d  = S_P2;
                    end else if (gap_to) begin
                        seq_err_d  = 1'b1;
                        err_code_d = ERR_GAP_TIMEOUT;
                        state_d    = S_WAIT_LOW;
                    end
                end
                S_P2: begin
                    if (fall) begin
                        m_pi_d  = run_len;
                        state_d = S_G2;
                    end else if (pulse_to) begin
                        seq_err_d  = 1'b1;
                        err_code_d = ERR_PULSE_TIMEOUT;
                        state_d    = S_WAIT_LOW;
                    end
                end
                S_G2: begin
                    if (rise) begin
                        m_gap2_d = run_len;
                        state_d  = S_P3;
                    end else if (gap_to) begin
                        seq_err_d  = 1'b1;
                        err_code_d = ERR_GAP_TIMEOUT;
                        state_d    = S_WAIT_LOW;
                    end
                end
                S_P3: begin
                    if (fall) begin
                        // publish the whole measurement with the verdict
                        t_pi2a_d   = m_pi2a_q;
                        t_gap1_d   = m_gap1_q;
                        t_pi_d     = m_pi_q;
                        t_gap2_d   = m_gap2_q;
                        t_pi2b_d   = run_len;
                        err_code_d = chk_code;
                        if (chk_code == ERR_NONE) begin
                            seq_valid_d = 1'b1;
                            seq_count_d = seq_count_q + 16'd1;
                        end else begin
                            seq_err_d = 1'b1;
                        end
                        state_d = S_REPORT;
                    end else if (pulse_to) begin
                        seq_err_d  = 1'b1;
                        err_code_d = ERR_PULSE_TIMEOUT;
                        state_d    = S_WAIT_LOW;
                    end
                end
                // a rise here starts the next sequence without losing it
                S_REPORT: state_d = rise ? S_P1 : S_WAIT_LOW;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seq_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
            seq_count_q <= '0;
            t_pi2a_q    <= '0;
            t_gap1_q    <= '0;
            t_pi_q      <= '0;
            t_gap2_q    <= '0;
            t_pi2b_q    <= '0;
            m_pi2a_q    <= '0;
            m_gap1_q    <= '0;
            m_pi_q      <= '0;
            m_gap2_q    <= '0;
        end else begin
            state_q     <= state_d;
            seq_valid_q <= seq_valid_d;
            seq_err_q   <= seq_err_d;
            err_code_q  <= err_code_d;
            seq_count_q <= seq_count_d;
            t_pi2a_q    <= t_pi2a_d;
            t_gap1_q    <= t_gap1_d;
            t_pi_q      <= t_pi_d;
            t_gap2_q    <= t_gap2_d;
            t_pi2b_q    <= t_pi2b_d;
            m_pi2a_q    <= m_pi2a_d;
            m_gap1_q    <= m_gap1_d;
            m_pi_q      <= m_pi_d;
            m_gap2_q    <= m_gap2_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_WAIT_LOW);
    assign bus.seq_valid = seq_valid_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.seq_count = seq_count_q;
    assign bus.t_pi2_a   = t_pi2a_q;
    assign bus.t_gap1    = t_gap1_q;
    assign bus.t_pi      = t_pi_q;
    assign bus.t_gap2    = t_gap2_q;
    assign bus.t_pi2_b   = t_pi2b_q;

endmodule

// File: tb/tb_rf_echo_decoder.sv
// Scoreboard bench for rf_echo_decoder: stimulus pushes the expected
// strobe (kind, code, lengths, count, arrival cycle); a negedge monitor
// pops and compares whenever seq_valid or seq_err is seen.
module tb_rf_echo_decoder;

`ifdef RF_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        valid;
        logic [2:0]  code;
        logic        lens;
        int          a, g1, p, g2, b;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    exp_t q[$];
    exp_t m;

    rf_echo_decoder_if bus ();

    rf_echo_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.rf = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic v, input logic [2:0] c, input logic lens,
                        input int a, input int g1, input int p, input int g2,
                        input int b, input int ec);
        exp_t e;
        if (v) exp_cnt++;
        e.valid = v; e.code = c; e.lens = lens;
        e.a = a; e.g1 = g1; e.p = p; e.g2 = g2; e.b = b;
        e.cnt = 16'(exp_cnt); e.cyc = ec;
        q.push_back(e);
    endtask

    // full five-segment sequence, then tail low cycles
    task automatic seq5(input int a, input int g1, input int p, input int g2,
                        input int b, input int tail, input logic v,
                        input logic [2:0] c);
        hold(1'b1, a); hold(1'b0, g1); hold(1'b1, p); hold(1'b0, g2); hold(1'b1, b);
        bus.rf = 1'b0;
        push(v, c, 1'b1, a, g1, p, g2, b, cyc + LAT);
        hold(1'b0, tail);
    endtask

    // monitor: compare every strobe against the head of the queue
    always @(negedge clk) begin
        if (bus.seq_valid || bus.seq_err) begin
            chk("strobe_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                m = q.pop_front();
                chk("seq_valid", int'(bus.seq_valid), int'(m.valid));
                chk("seq_err", int'(bus.seq_err), int'(!m.valid));
                chk("err_code", int'(bus.err_code), int'(m.code));
                chk("strobe_cycle", cyc, m.cyc);
                chk("seq_count", int'(bus.seq_count), int'(m.cnt));
                if (m.lens) begin
                    chk("t_pi2_a", int'(bus.t_pi2_a), m.a);
                    chk("t_gap1", int'(bus.t_gap1), m.g1);
                    chk("t_pi", int'(bus.t_pi), m.p);
                    chk("t_gap2", int'(bus.t_gap2), m.g2);
                    chk("t_pi2_b", int'(bus.t_pi2_b), m.b);
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_valid"}, int'(bus.seq_valid), 0);
        chk({tag, "_err"}, int'(bus.seq_err), 0);
        chk({tag, "_code"}, int'(bus.err_code), 0);
        chk({tag, "_count"}, int'(bus.seq_count), 0);
        chk({tag, "_pi2a"}, int'(bus.t_pi2_a), 0);
        chk({tag, "_gap1"}, int'(bus.t_gap1), 0);
        chk({tag, "_pi"}, int'(bus.t_pi), 0);
        chk({tag, "_gap2"}, int'(bus.t_gap2), 0);
        chk({tag, "_pi2b"}, int'(bus.t_pi2_b), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus.arm = 1'b0; bus.rf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        hold(1'b0, 2);
        bus.arm = 1'b1;
        hold(1'b0, 3);

        // basic valid echo and the three consistency failures
        seq5(10, 20, 20, 20, 10, 5, 1'b1, 3'd0);
        seq5(10, 20, 25, 20, 10, 5, 1'b0, 3'd1);
        seq5(10, 20, 20, 24, 10, 5, 1'b0, 3'd3);
        seq5(10, 20, 20, 22, 10, 5, 1'b1, 3'd0);
        seq5(10, 20, 20, 20, 13, 5, 1'b0, 3'd2);
        // tolerance edge passes; all-fail reports the first check
        seq5(10, 20, 22, 20, 12, 5, 1'b1, 3'd0);
        seq5(10, 20, 25, 24, 14, 5, 1'b0, 3'd1);

        // gap timeout on the 1001st low cycle, then recovery
        hold(1'b1, 10);
        bus.rf = 1'b0;
        push(1'b0, 3'd4, 1'b0, 0, 0, 0, 0, 0, cyc + 1000 + LAT);
        hold(1'b0, 1010);
        seq5(10, 20, 20, 20, 10, 5, 1'b1, 3'd0);

        // pulse timeout on the 501st high cycle; rest of the pulse ignored
        bus.rf = 1'b1;
        push(1'b0, 3'd5, 1'b0, 0, 0, 0, 0, 0, cyc + 500 + LAT);
        hold(1'b1, 600);
        hold(1'b0, 5);

        // back-to-back: next rise lands in the REPORT cycle
        seq5(10, 20, 20, 20, 10, 1, 1'b1, 3'd0);
        seq5(12, 16, 24, 16, 12, 5, 1'b1, 3'd0);

        // arm drop mid-G1: silent abort
        hold(1'b1, 10);
        hold(1'b0, 5);
        bus.arm = 1'b0;
        hold(1'b0, 3);
        bus.arm = 1'b1;
        hold(1'b0, 3);
        seq5(10, 20, 20, 20, 10, 5, 1'b1, 3'd0);

        // pulse already high at arm time is ignored
        bus.arm = 1'b0;
        hold(1'b0, 2);
        hold(1'b1, 3);
        bus.arm = 1'b1;
        hold(1'b1, 15);
        hold(1'b0, 5);
        seq5(10, 20, 20, 20, 10, 5, 1'b1, 3'd0);

        // reset mid-G2 clears everything with no strobe
        hold(1'b1, 10); hold(1'b0, 20); hold(1'b1, 20); hold(1'b0, 5);
        chk("busy_in_g2", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("mid_rst");
        rst = 1'b0;
        exp_cnt = 0;
        hold(1'b0, 3);
        seq5(10, 20, 20, 20, 10, 10, 1'b1, 3'd0);

        chk("pending_at_end", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
